// File: rtl/plot_frame_monitor_if.sv
// Pixel-plot bus shared by the sprite drawers, the VGA adapter and the frame monitor.
// The drawer drives it through master; the adapter and the monitor only listen through slave.
interface plot_frame_monitor_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (output x, output y, output colour, output plot);
  modport slave  (input  x, input  y, input  colour, input  plot);
endinterface

// File: rtl/plot_frame_monitor.sv
// Raster-order checker for the pixel-plot bus: counts pixels, flags ordering/range errors, marks frame completion.
// Optional running frame signature enabled by defining PLOT_FRAME_CHECKSUM_EN.
module plot_frame_monitor #(
  parameter int         WIDTH     = 160,
  parameter int         HEIGHT    = 120,
  parameter logic [2:0] BG_COLOUR = 3'b010
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                clear,
  plot_frame_monitor_if.slave bus,
  output logic                frame_done,
  output logic                error,
  output logic [14:0]         pixel_count,
  output logic [14:0]         fg_count,
  output logic [15:0]         checksum,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE, ERROR} state_t;

  localparam logic [7:0] X_LIM  = 8'(WIDTH);
  localparam logic [6:0] Y_LIM  = 7'(HEIGHT);
  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  ex_reg, ex_next;
  logic [6:0]  ey_reg, ey_next;
  logic [14:0] pixel_count_reg, pixel_count_next;
  logic [14:0] fg_count_reg, fg_count_next;
  logic        frame_done_reg, error_reg, busy_reg;
  logic        accept, restart;
  logic        in_range, at_origin, at_last, at_expected, is_fg;

  assign in_range    = (bus.x < X_LIM) && (bus.y < Y_LIM);
  assign at_origin   = (bus.x == 8'd0) && (bus.y == 7'd0);
  assign at_last     = (bus.x == X_LAST) && (bus.y == Y_LAST);
  assign at_expected = (bus.x == ex_reg) && (bus.y == ey_reg);
  assign is_fg       = (bus.colour != BG_COLOUR);

  always_comb begin
    state_next       = state_reg;
    ex_next          = ex_reg;
    ey_next          = ey_reg;
    pixel_count_next = pixel_count_reg;
    fg_count_next    = fg_count_reg;
    accept           = 1'b0;
    restart          = 1'b0;

    case (state_reg)
      IDLE: begin
        // Anything other than the origin is mid-frame traffic seen before sync.
        if (bus.plot && at_origin) begin
          restart    = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.plot) begin
          if (in_range && at_expected) begin
            accept = 1'b1;
            if (at_last) state_next = DONE;
          end else begin
            state_next = ERROR;
          end
        end
      end
      DONE: begin
        if (bus.plot) begin
          if (at_origin) begin
            restart    = 1'b1;
            state_next = CAPTURE;
          end else begin
            state_next = ERROR;
          end
        end
      end
      default: ;
    endcase

    if (restart) begin
      pixel_count_next = 15'd1;
      fg_count_next    = {14'd0, is_fg};
      ex_next          = 8'd1;
      ey_next          = 7'd0;
    end else if (accept) begin
      pixel_count_next = pixel_count_reg + 15'd1;
      fg_count_next    = fg_count_reg + {14'd0, is_fg};
      if (ex_reg == X_LAST) begin
        ex_next = 8'd0;
        ey_next = ey_reg + 7'd1;
      end else begin
        ex_next = ex_reg + 8'd1;
      end
    end

    if (clear) begin
      state_next       = IDLE;
      ex_next          = 8'd0;
      ey_next          = 7'd0;
      pixel_count_next = 15'd0;
      fg_count_next    = 15'd0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= IDLE;
      ex_reg          <= 8'd0;
      ey_reg          <= 7'd0;
      pixel_count_reg <= 15'd0;
      fg_count_reg    <= 15'd0;
      frame_done_reg  <= 1'b0;
      error_reg       <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ex_reg          <= ex_next;
      ey_reg          <= ey_next;
      pixel_count_reg <= pixel_count_next;
      fg_count_reg    <= fg_count_next;
      frame_done_reg  <= (state_next == DONE);
      error_reg       <= (state_next == ERROR);
      busy_reg        <= (state_next == CAPTURE);
    end
  end

  assign frame_done  = frame_done_reg;
  assign error       = error_reg;
  assign busy        = busy_reg;
  assign pixel_count = pixel_count_reg;
  assign fg_count    = fg_count_reg;

`ifdef PLOT_FRAME_CHECKSUM_EN
  logic [15:0] checksum_reg, checksum_next;

  // Rotate-left then fold in the colour; a restart seeds from zero.
  always_comb begin
    checksum_next = checksum_reg;
    if (restart)
      checksum_next = {13'd0, bus.colour};
    else if (accept)
      checksum_next = {checksum_reg[14:0], checksum_reg[15]} ^ {13'd0, bus.colour};
    if (clear)
      checksum_next = 16'h0000;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) checksum_reg <= 16'h0000;
    else         checksum_reg <= checksum_next;
  end

  assign checksum = checksum_reg;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_plot_frame_monitor.sv
// Self-checking bench for plot_frame_monitor: hand vectors, full frames, corner sequences and
// randomized traffic compared against a linear-index reference model.
module tb_plot_frame_monitor;
  localparam int         W  = 160;
  localparam int         H  = 120;
  localparam logic [2:0] BG = 3'b010;

  logic        CLOCK_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic        clear    = 1'b0;
  logic        frame_done, error, busy;
  logic [14:0] pixel_count, fg_count;
  logic [15:0] checksum;

  plot_frame_monitor_if bus ();

  plot_frame_monitor #(.WIDTH(W), .HEIGHT(H), .BG_COLOUR(BG)) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .clear      (clear),
    .bus        (bus),
    .frame_done (frame_done),
    .error      (error),
    .pixel_count(pixel_count),
    .fg_count   (fg_count),
    .checksum   (checksum),
    .busy       (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int passes = 0;

  // Reference model: the accepted count doubles as the linear index of the next legal pixel.
  int          m_count, m_fg;
  logic [15:0] m_cs;
  bit          m_capturing, m_done, m_err;

  function automatic void model_reset();
    m_count = 0; m_fg = 0; m_cs = 16'h0000;
    m_capturing = 0; m_done = 0; m_err = 0;
  endfunction

  function automatic void model_accept(logic [2:0] col);
    m_count++;
    if (col != BG) m_fg++;
`ifdef PLOT_FRAME_CHECKSUM_EN
    m_cs = {m_cs[14:0], m_cs[15]} ^ {13'd0, col};
`endif
    if (m_count == W * H) begin
      m_done = 1; m_capturing = 0;
    end
  endfunction

  function automatic void model_step(bit clr, bit pl, int px, int py, logic [2:0] col);
    if (clr) begin
      model_reset();
      return;
    end
    if (!pl || m_err) return;
    if (m_capturing) begin
      if (px < W && py < H && (py * W + px) == m_count) model_accept(col);
      else begin m_err = 1; m_capturing = 0; end
    end else if (px == 0 && py == 0) begin
      m_count = 0; m_fg = 0; m_cs = 16'h0000;
      m_done = 0; m_capturing = 1;
      model_accept(col);
    end else if (m_done) begin
      m_err = 1; m_done = 0;
    end
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_model(string name);
    checks++;
    if (frame_done === m_done && error === m_err && busy === m_capturing &&
        pixel_count === 15'(m_count) && fg_count === 15'(m_fg) && checksum === m_cs)
      passes++;
    else
      $display("FAIL %s: got fd=%0d err=%0d busy=%0d pc=%0d fg=%0d cs=%h, expected fd=%0d err=%0d busy=%0d pc=%0d fg=%0d cs=%h",
               name, frame_done, error, busy, pixel_count, fg_count, checksum,
               m_done, m_err, m_capturing, m_count, m_fg, m_cs);
  endtask

  task automatic step(bit clr, bit pl, int px, int py, logic [2:0] col, bit do_chk, string name);
    clear      = clr;
    bus.plot   = pl;
    bus.x      = 8'(px);
    bus.y      = 7'(py);
    bus.colour = col;
    @(posedge CLOCK_50);
    #1;
    model_step(clr, pl, int'(bus.x), int'(bus.y), col);
    clear    = 1'b0;
    bus.plot = 1'b0;
    if (do_chk) check_model(name);
  endtask

  typedef struct {
    bit         clr;
    bit         pl;
    int         px;
    int         py;
    logic [2:0] col;
    bit         fd;
    bit         er;
    int         pc;
    int         fg;
    bit         bz;
  } vec_t;

  vec_t tbl[14];

  initial begin
    bus.x = 8'd0; bus.y = 7'd0; bus.colour = 3'd0; bus.plot = 1'b0;
    model_reset();

    tbl[0]  = '{0, 1, 10, 3, 3'd7, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 11, 3, 3'd7, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1,  0, 0, 3'd7, 0, 0, 1, 1, 1};
    tbl[3]  = '{0, 0,  5, 5, 3'd7, 0, 0, 1, 1, 1};
    tbl[4]  = '{0, 1,  1, 0, 3'd2, 0, 0, 2, 1, 1};
    tbl[5]  = '{0, 1,  2, 0, 3'd1, 0, 0, 3, 2, 1};
    tbl[6]  = '{0, 1,  3, 0, 3'd2, 0, 0, 4, 2, 1};
    tbl[7]  = '{0, 1,  4, 0, 3'd2, 0, 0, 5, 2, 1};
    tbl[8]  = '{0, 1,  6, 0, 3'd2, 0, 1, 5, 2, 0};
    tbl[9]  = '{0, 1,  5, 0, 3'd2, 0, 1, 5, 2, 0};
    tbl[10] = '{0, 0,  0, 0, 3'd2, 0, 1, 5, 2, 0};
    tbl[11] = '{1, 1,  0, 0, 3'd2, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 1,  0, 0, 3'd2, 0, 0, 1, 0, 1};
    tbl[13] = '{1, 0,  0, 0, 3'd2, 0, 0, 0, 0, 0};

    // Reset state
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("reset_outputs", {frame_done, error, busy, pixel_count, fg_count, checksum}, 32'd0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    step(0, 0, 0, 0, BG, 1, "idle_after_reset");

    // Hand vectors: IDLE ignore, skip pixel, sticky error, clear priority
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].clr, tbl[i].pl, tbl[i].px, tbl[i].py, tbl[i].col, 0, "");
      check($sformatf("vec%0d", i),
            {frame_done, error, busy, pixel_count, fg_count},
            {tbl[i].fd, tbl[i].er, tbl[i].bz, 15'(tbl[i].pc), 15'(tbl[i].fg)});
    end
    model_reset();

    // Frame 1: background, back to back
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        step(0, 1, xx, yy, BG, xx == W - 1, "frame1_row");
    check("frame1_done", frame_done, 1);
    check("frame1_count", pixel_count, 19200);
    check("frame1_fg", fg_count, 0);
    check("frame1_busy", busy, 0);
    check("frame1_checksum", checksum, m_cs);

    // Non-origin plot from DONE: error with frozen counts
    step(0, 1, 7, 0, BG, 1, "done_bad_plot");
    check("done_bad_error", error, 1);
    check("done_bad_count", pixel_count, 19200);
    step(1, 0, 0, 0, BG, 1, "clear_after_done_bad");

    // Frame 2: foreground rows 0-9, random gaps
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        while ($urandom_range(7) == 0) step(0, 0, 0, 0, BG, 0, "");
        step(0, 1, xx, yy, (yy < 10) ? 3'b111 : BG, xx == W - 1, "frame2_row");
      end
    check("frame2_done", frame_done, 1);
    check("frame2_count", pixel_count, 19200);
    check("frame2_fg", fg_count, 1600);

    // Restart from DONE, then complete frame 3
    step(0, 1, 0, 0, 3'b111, 1, "restart");
    check("restart_count", pixel_count, 1);
    check("restart_fg", fg_count, 1);
    check("restart_busy", busy, 1);
    for (int i = 1; i < W * H; i++)
      step(0, 1, i % W, i / W, 3'(i), (i % W) == W - 1, "frame3_row");
    check("frame3_done", frame_done, 1);

    // clear beats plot from DONE
    step(1, 1, 0, 0, BG, 1, "clear_beats_plot");
    check("clear_plot_busy", busy, 0);
    check("clear_plot_count", pixel_count, 0);

    // Drawer overshoot at x=160
    for (int xx = 0; xx < W; xx++) step(0, 1, xx, 0, BG, 0, "");
    step(0, 1, 160, 0, BG, 1, "overshoot");
    check("overshoot_error", error, 1);
    check("overshoot_count", pixel_count, 160);
    step(1, 0, 0, 0, BG, 1, "clear_after_overshoot");

    // Asynchronous reset mid-frame
    for (int i = 0; i < 5000; i++) step(0, 1, i % W, i / W, 3'($urandom_range(7)), 0, "");
    check_model("before_async_reset");
    #2 resetn = 1'b0;
    #1;
    check("async_reset_outputs", {frame_done, error, busy, pixel_count, fg_count, checksum}, 32'd0);
    model_reset();
    #3 resetn = 1'b1;
    step(0, 1, 7, 7, BG, 1, "post_reset_ignore");
    step(0, 1, 0, 0, BG, 1, "post_reset_sync");
    check("post_reset_busy", busy, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = int'($urandom_range(99));
      if (r < 4)       step(1, $urandom_range(1), 0, 0, BG, 1, "rand_clear");
      else if (r < 12) step(0, 0, 0, 0, BG, 1, "rand_gap");
      else if (r < 80) step(0, 1, m_count % W, m_count / W, 3'($urandom_range(7)), 1, "rand_inorder");
      else if (r < 90) step(0, 1, 0, 0, 3'($urandom_range(7)), 1, "rand_origin");
      else             step(0, 1, $urandom_range(170), $urandom_range(127), 3'($urandom_range(7)), 1, "rand_any");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
